// File: rtl/fft_8p_input_buffer_if.sv
// ---------------------------------------------------------------------------
// fft_8p_input_buffer_if
// Bus bundle between the serial sample source / FFT control and the 8-point
// FFT input buffer.
//   in_valid, in_re, in_im : serial sample stream into the buffer
//   in_ready               : buffer can take a sample this cycle
//   en_s2p                 : presented frame is consumed this cycle
//   start                  : 1-cycle pulse when a new frame is first presented
//   frame_valid            : par_re/par_im hold a complete, unconsumed frame
//   par_re, par_im         : 8 slots, slot j at [j*DATA_W +: DATA_W]
//   err_unexp              : sticky, en_s2p seen with no frame presented
// master = upstream source / control side, slave = the buffer itself.
// ---------------------------------------------------------------------------
interface fft_8p_input_buffer_if #(
    parameter int DATA_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_re;
    logic [DATA_W-1:0]     in_im;
    logic                  en_s2p;
    logic                  start;
    logic                  frame_valid;
    logic [8*DATA_W-1:0]   par_re;
    logic [8*DATA_W-1:0]   par_im;
    logic                  err_unexp;

    modport master (
        output in_valid, in_re, in_im, en_s2p,
        input  in_ready, start, frame_valid, par_re, par_im, err_unexp
    );

    modport slave (
        input  in_valid, in_re, in_im, en_s2p,
        output in_ready, start, frame_valid, par_re, par_im, err_unexp
    );
endinterface

// File: rtl/fft_8p_input_buffer.sv
// ---------------------------------------------------------------------------
// fft_8p_input_buffer
// Serial-to-parallel input stage of the 8-point FFT. Samples are collected
// into one of two ping-pong banks; a full bank is presented in parallel
// (optionally in bit-reversed slot order) and a start pulse is raised for
// the FFT control FSM. The frame is released by en_s2p.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous reset, active-low
//   bus      : slave side of fft_8p_input_buffer_if (sample stream in,
//              parallel frame + start/frame_valid/err_unexp out)
//
// Bank state | meaning
// -----------+-----------------------------------------------------------
// EMPTY      | no data, may be written
// FILLING    | 1..7 samples written
// FULL       | 8 samples, waiting for the read side
// PRESENTED  | on par_re/par_im, waiting for en_s2p
// ---------------------------------------------------------------------------
module fft_8p_input_buffer #(
    parameter int DATA_W      = 16,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    fft_8p_input_buffer_if.slave      bus
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_PRESENTED
    } bank_state_t;

    bank_state_t           bank_q [2];
    bank_state_t           bank_d [2];
    logic [2:0]            wr_cnt_q, wr_cnt_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  start_q, start_d;
    logic                  err_q, err_d;
    logic [8*DATA_W-1:0]   par_re_q, par_re_d;
    logic [8*DATA_W-1:0]   par_im_q, par_im_d;

    // Bank storage is not reset; bank state alone decides what is valid.
    logic [DATA_W-1:0]     mem_re [2][8];
    logic [DATA_W-1:0]     mem_im [2][8];

    logic                  in_ready;
    logic                  frame_valid;
    logic                  accept;
    logic                  consume;
    logic [2:0]            wr_slot;
    logic [8*DATA_W-1:0]   frame_re;
    logic [8*DATA_W-1:0]   frame_im;

    // Only the read bank can ever be PRESENTED.
    assign in_ready    = (bank_q[wr_bank_q] == BANK_EMPTY) ||
                         (bank_q[wr_bank_q] == BANK_FILLING);
    assign frame_valid = (bank_q[rd_bank_q] == BANK_PRESENTED);
    assign accept      = bus.in_valid & in_ready;
    assign consume     = bus.en_s2p & frame_valid;
    assign wr_slot     = BIT_REVERSE ? {wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2]}
                                     : wr_cnt_q;

    // Frame image of the bank about to be read, with the sample written on
    // this edge forwarded in so an 8th accept can be presented immediately.
    always_comb begin
        frame_re = '0;
        frame_im = '0;
        for (int j = 0; j < 8; j++) begin
            frame_re[j*DATA_W +: DATA_W] = mem_re[rd_bank_d][j];
            frame_im[j*DATA_W +: DATA_W] = mem_im[rd_bank_d][j];
            if (accept && (wr_bank_q == rd_bank_d) && (wr_slot == 3'(j))) begin
                frame_re[j*DATA_W +: DATA_W] = bus.in_re;
                frame_im[j*DATA_W +: DATA_W] = bus.in_im;
            end
        end
    end

    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        start_d   = 1'b0;
        err_d     = err_q | (bus.en_s2p & ~frame_valid);
        par_re_d  = par_re_q;
        par_im_d  = par_im_q;

        if (consume) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end

        // Accept and consume always target different banks: the write bank
        // is EMPTY/FILLING while the consumed bank is PRESENTED.
        if (accept) begin
            if (wr_cnt_q == 3'd7) begin
                bank_d[wr_bank_q] = BANK_FULL;
                wr_cnt_d          = 3'd0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                bank_d[wr_bank_q] = BANK_FILLING;
                wr_cnt_d          = wr_cnt_q + 3'd1;
            end
        end

        // Present on the same edge the read bank becomes (or already is)
        // FULL, so frame_valid/start appear the cycle after the 8th accept
        // or the consume.
        if ((bank_d[0] != BANK_PRESENTED) && (bank_d[1] != BANK_PRESENTED) &&
            (bank_d[rd_bank_d] == BANK_FULL)) begin
            bank_d[rd_bank_d] = BANK_PRESENTED;
            start_d           = 1'b1;
            par_re_d          = frame_re;
            par_im_d          = frame_im;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_cnt_q  <= 3'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
            par_re_q  <= '0;
            par_im_q  <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            start_q   <= start_d;
            err_q     <= err_d;
            par_re_q  <= par_re_d;
            par_im_q  <= par_im_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            mem_re[wr_bank_q][wr_slot] <= bus.in_re;
            mem_im[wr_bank_q][wr_slot] <= bus.in_im;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.frame_valid = frame_valid;
    assign bus.start       = start_q;
    assign bus.err_unexp   = err_q;
    assign bus.par_re      = par_re_q;
    assign bus.par_im      = par_im_q;

endmodule

// File: tb/tb_fft_8p_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_fft_8p_input_buffer
// Directed scenarios plus a randomized phase, every cycle compared against a
// frame-queue reference model (partial frame + queue of complete frames).
// ---------------------------------------------------------------------------
module tb_fft_8p_input_buffer;
    localparam int W  = 16;
    localparam bit BR = 1'b1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    fft_8p_input_buffer_if #(.DATA_W(W)) bus ();

    fft_8p_input_buffer #(.DATA_W(W), .BIT_REVERSE(BR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: complete frames in arrival order (sample k at k*W),
    // the partial frame being collected, and what par_* should show.
    logic [8*W-1:0] q_re[$];
    logic [8*W-1:0] q_im[$];
    logic [W-1:0]   p_re [8];
    logic [W-1:0]   p_im [8];
    int             p_cnt;
    logic [8*W-1:0] last_re, last_im;
    bit             m_start, m_err;

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*W-1:0] to_slots(input logic [8*W-1:0] s);
        logic [8*W-1:0] r;
        logic [2:0]     jj, idx;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            jj  = 3'(j);
            idx = BR ? {jj[0], jj[1], jj[2]} : jj;
            r[j*W +: W] = s[int'(idx)*W +: W];
        end
        return r;
    endfunction

    task automatic model_clear();
        q_re.delete();
        q_im.delete();
        p_cnt   = 0;
        last_re = '0;
        last_im = '0;
        m_start = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic check_all();
        chk("in_ready",    {127'b0, bus.in_ready},    {127'b0, q_re.size() < 2});
        chk("frame_valid", {127'b0, bus.frame_valid}, {127'b0, q_re.size() > 0});
        chk("start",       {127'b0, bus.start},       {127'b0, m_start});
        chk("err_unexp",   {127'b0, bus.err_unexp},   {127'b0, m_err});
        chk("par_re",      bus.par_re, last_re);
        chk("par_im",      bus.par_im, last_im);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic step(input bit iv, input logic [W-1:0] re, input logic [W-1:0] im,
                        input bit en, output bit acc);
        int             nf_old;
        bit             fv, consume;
        logic [8*W-1:0] f_re, f_im;
        bus.in_valid = iv;
        bus.in_re    = re;
        bus.in_im    = im;
        bus.en_s2p   = en;
        nf_old  = q_re.size();
        fv      = (nf_old > 0);
        acc     = iv && (nf_old < 2);
        consume = en && fv;
        @(posedge clk);
        #1;
        if (consume) begin
            void'(q_re.pop_front());
            void'(q_im.pop_front());
        end
        if (acc) begin
            p_re[p_cnt] = re;
            p_im[p_cnt] = im;
            p_cnt++;
            if (p_cnt == 8) begin
                for (int k = 0; k < 8; k++) begin
                    f_re[k*W +: W] = p_re[k];
                    f_im[k*W +: W] = p_im[k];
                end
                q_re.push_back(f_re);
                q_im.push_back(f_im);
                p_cnt = 0;
            end
        end
        if (en && !fv) m_err = 1'b1;
        m_start = (q_re.size() > 0) && (consume || nf_old == 0);
        if (m_start) begin
            last_re = to_slots(q_re[0]);
            last_im = to_slots(q_im[0]);
        end
        bus.in_valid = 1'b0;
        bus.en_s2p   = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, acc);
    endtask

    task automatic send(input int val, input bit en);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, W'(val), W'(-val), en, acc);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.en_s2p   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
        chk("rst_in_ready", {127'b0, bus.in_ready}, 1);
        check_all();
    endtask

    // Known answer for samples re=k+1, im=-(k+1), k=0..7, bit-reversed slots.
    task automatic chk_known(input string tag);
        int             slots [8];
        logic [8*W-1:0] e_re, e_im;
        slots = '{1, 5, 3, 7, 2, 6, 4, 8};
        for (int j = 0; j < 8; j++) begin
            e_re[j*W +: W] = W'(slots[j]);
            e_im[j*W +: W] = W'(-slots[j]);
        end
        chk({tag, "_re"}, bus.par_re, e_re);
        chk({tag, "_im"}, bus.par_im, e_im);
    endtask

    initial begin
        bit acc;
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        bus.en_s2p   = 1'b0;
        model_clear();

        // 1: one frame, latency, bit-reversed layout
        do_reset();
        for (int k = 0; k < 8; k++) send(k + 1, 1'b0);
        chk("s1_start", {127'b0, bus.start}, 1);
        chk("s1_fv", {127'b0, bus.frame_valid}, 1);
        chk_known("s1_par");
        idle(1);
        chk("s1_start_drop", {127'b0, bus.start}, 0);

        // 2: back-pressure with both banks occupied
        for (int k = 8; k < 16; k++) send(k + 1, 1'b0);
        chk("s2_not_ready", {127'b0, bus.in_ready}, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, W'(17), W'(-17), 1'b0, acc);
            chk("s2_held", {127'b0, acc}, 0);
        end
        chk_known("s2_frame1_kept");
        step(1'b1, W'(17), W'(-17), 1'b1, acc);
        chk("s2_frame2_start", {127'b0, bus.start}, 1);
        chk("s2_ready_again", {127'b0, bus.in_ready}, 1);
        send(17, 1'b0);

        // 3: 8th sample of the next frame on the consume edge
        for (int k = 18; k < 24; k++) send(k, 1'b0);
        step(1'b1, W'(24), W'(-24), 1'b1, acc);
        chk("s3_acc", {127'b0, acc}, 1);
        chk("s3_start", {127'b0, bus.start}, 1);
        chk("s3_fv", {127'b0, bus.frame_valid}, 1);
        step(1'b0, '0, '0, 1'b1, acc);
        chk("s3_drained", {127'b0, bus.frame_valid}, 0);

        // 4: reset discards a partial frame
        do_reset();
        for (int k = 0; k < 5; k++) send(100 + k, 1'b0);
        do_reset();
        for (int k = 0; k < 8; k++) send(k + 1, 1'b0);
        chk_known("s4_par");

        // 5: unexpected en_s2p, sticky error, nothing else disturbed
        do_reset();
        step(1'b0, '0, '0, 1'b1, acc);
        chk("s5_err", {127'b0, bus.err_unexp}, 1);
        for (int k = 0; k < 3; k++) send(k + 1, 1'b0);
        step(1'b0, '0, '0, 1'b1, acc);
        for (int k = 3; k < 8; k++) send(k + 1, 1'b0);
        chk_known("s5_par");
        idle(3);
        chk("s5_err_sticky", {127'b0, bus.err_unexp}, 1);

        // 6: in_valid alternating
        do_reset();
        for (int i = 0; i < 16; i++)
            step(i % 2 == 0, W'(i / 2 + 1), W'(-(i / 2 + 1)), 1'b0, acc);
        chk_known("s6_par");

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step($urandom_range(0, 9) < 7, W'($urandom), W'($urandom),
                 $urandom_range(0, 9) < 3, acc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
